// File: rtl/top_level.sv
// Single-cycle 8-bit accumulator processor.
// R0 is the accumulator. Every ALU result, immediate load and memory load
// lands in R0. PUT is the only instruction that writes another register.
// The instruction ROM, register file and data RAM are separate instances,
// so their storage arrays can be preloaded by name.

module instr_rom #(
  parameter int IW = 9,
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_addr,
  output logic [IW-1:0] o_instr
);
  // The program image is written in from outside. No logic here drives it.
  logic [IW-1:0] instr_memory [256];

  assign o_instr = instr_memory[i_addr];
endmodule

module reg_file #(
  parameter int DW = 8,
  parameter int NR = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [2:0]    i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [2:0]    i_raddr,
  output logic [DW-1:0] o_acc,
  output logic [DW-1:0] o_rdata
);
  // The contents are not reset, because they are preloaded before a run.
  logic [DW-1:0] registers [NR];

  assign o_acc   = registers[0];
  assign o_rdata = registers[i_raddr];

  // Single write port. Reads are combinational and return the value held before the edge.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      registers[i_waddr] <= i_wdata;
    end
  end
endmodule

module data_ram #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [DW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] my_memory [256];

  assign o_rdata = my_memory[i_addr];

  // Store at the clock edge. The read port is combinational.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      my_memory[i_addr] <= i_wdata;
    end
  end
endmodule

module top_level #(
  parameter int IW = 9,
  parameter int DW = 8,
  parameter int NR = 8
) (
  input  logic          CLK,
  input  logic          start,
  input  logic [DW-1:0] start_addr,
  output logic          done
);
  localparam logic [3:0] OP_LDI  = 4'd0;
  localparam logic [3:0] OP_PUT  = 4'd1;
  localparam logic [3:0] OP_GET  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_ORR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_PAR  = 4'd9;
  localparam logic [3:0] OP_LD   = 4'd10;
  localparam logic [3:0] OP_ST   = 4'd11;
  localparam logic [3:0] OP_BZ   = 4'd12;
  localparam logic [3:0] OP_BNZ  = 4'd13;
  localparam logic [3:0] OP_LDH  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  logic [DW-1:0] r_pc;
  logic          r_done;

  logic [IW-1:0] w_instr;
  logic [3:0]    w_op;
  logic [4:0]    w_f;
  logic [2:0]    w_r;
  logic [DW-1:0] w_acc;
  logic [DW-1:0] w_rr;
  logic [DW-1:0] w_ram_rdata;
  logic          w_run;

  logic          w_rf_we;
  logic [2:0]    w_rf_waddr;
  logic [DW-1:0] w_rf_wdata;
  logic          w_ram_we;
  logic [DW-1:0] w_pc_next;
  logic          w_halt;

  assign w_op  = w_instr[8:5];
  assign w_f   = w_instr[4:0];
  assign w_r   = w_f[2:0];
  // Nothing executes while start is held or after HALT.
  assign w_run = ~start & ~r_done;
  assign done  = r_done;

  instr_rom #(.IW(IW), .DW(DW)) InstrROM_module (
    .i_addr  (r_pc),
    .o_instr (w_instr)
  );

  reg_file #(.DW(DW), .NR(NR)) regFile_module (
    .i_clk   (CLK),
    .i_we    (w_rf_we & w_run),
    .i_waddr (w_rf_waddr),
    .i_wdata (w_rf_wdata),
    .i_raddr (w_r),
    .o_acc   (w_acc),
    .o_rdata (w_rr)
  );

  data_ram #(.DW(DW)) DataRAM_module (
    .i_clk   (CLK),
    .i_we    (w_ram_we & w_run),
    .i_addr  (w_rr),
    .i_wdata (w_acc),
    .o_rdata (w_ram_rdata)
  );

  // Decode the current instruction into a register write, a RAM write, the next PC and HALT.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = 3'd0;
    w_rf_wdata = w_acc;
    w_ram_we   = 1'b0;
    w_pc_next  = r_pc + 8'd1;
    w_halt     = 1'b0;
    case (w_op)
      OP_LDI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = {3'b000, w_f};
      end
      OP_PUT: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = w_r;
        w_rf_wdata = w_acc;
      end
      OP_GET: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_rr;
      end
      OP_ADD: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_acc + w_rr;
      end
      OP_SUB: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_acc - w_rr;
      end
      OP_XOR: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_acc ^ w_rr;
      end
      OP_AND: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_acc & w_rr;
      end
      OP_ORR: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_acc | w_rr;
      end
      OP_SHL: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_acc << w_f[2:0];
      end
      OP_PAR: begin
        // Parity of the tapped bits. This is the LFSR feedback bit.
        w_rf_we    = 1'b1;
        w_rf_wdata = {7'b0000000, ^(w_acc & w_rr)};
      end
      OP_LD: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_ram_rdata;
      end
      OP_ST: begin
        w_ram_we = 1'b1;
      end
      OP_BZ: begin
        if (w_acc == 8'd0) begin
          w_pc_next = w_rr;
        end else begin
          w_pc_next = r_pc + 8'd1;
        end
      end
      OP_BNZ: begin
        if (w_acc != 8'd0) begin
          w_pc_next = w_rr;
        end else begin
          w_pc_next = r_pc + 8'd1;
        end
      end
      OP_LDH: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = {w_f[2:0], w_acc[4:0]};
      end
      OP_HALT: begin
        w_halt    = 1'b1;
        w_pc_next = r_pc;
      end
      default: begin
        w_rf_we   = 1'b0;
        w_ram_we  = 1'b0;
        w_pc_next = r_pc + 8'd1;
      end
    endcase
  end

  // PC and done state. Start reloads the PC and aborts any run. HALT freezes the machine.
  always_ff @(posedge CLK) begin
    if (start) begin
      r_pc   <= start_addr;
      r_done <= 1'b0;
    end else if (!r_done) begin
      if (w_halt) begin
        r_done <= 1'b1;
      end else begin
        r_pc <= w_pc_next;
      end
    end else begin
      r_pc   <= r_pc;
      r_done <= r_done;
    end
  end
endmodule

// File: tb/tb_top_level.sv
// Scoreboard bench for top_level. Each test assembles a small program and
// preloads the ROM, registers and RAM. It queues the expected final state,
// then releases start. A separate monitor drains the queue when done rises.
module tb_top_level;
  logic       CLK = 1'b0;
  logic       start = 1'b1;
  logic [7:0] start_addr = 8'd0;
  logic       done;

  top_level dut (.CLK(CLK), .start(start), .start_addr(start_addr), .done(done));

  always #5 CLK = ~CLK;

  typedef struct {
    int         kind;   // 0 register, 1 RAM, 2 PC
    int         idx;
    logic [7:0] val;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] prog [256];
  int         apc;
  logic       mon_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: on the first sampled cycle with done high, compare every queued expectation.
  always @(negedge CLK) begin : monitor
    exp_t e;
    int   act;
    if (done === 1'b1 && mon_prev == 1'b0) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          0: act = int'(dut.regFile_module.registers[e.idx]);
          1: act = int'(dut.DataRAM_module.my_memory[e.idx]);
          default: act = int'(dut.r_pc);
        endcase
        check($sformatf("k%0d[%0d]", e.kind, e.idx), act, int'(e.val));
      end
    end
    mon_prev = done;
  end

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int ref_alu(input int op, input int a, input int b, input int sh);
    case (op)
      3: return (a + b) % 256;
      4: return (a - b + 256) % 256;
      5: return a ^ b;
      6: return a & b;
      7: return a | b;
      8: return (a * (1 << sh)) % 256;
      9: return $countones(a & b) % 2;
      default: return 0;
    endcase
  endfunction

  function automatic int lfsr_next(input int s, input int tap);
    return (s * 2 + ($countones(s & tap) % 2)) % 256;
  endfunction

  // ---------------- tiny assembler ----------------
  task automatic asm_i(input int op, input int f);
    prog[apc] = {op[3:0], f[4:0]};
    apc = (apc + 1) % 256;
  endtask

  task automatic cst(input int v);
    asm_i(0, v % 32);
    asm_i(14, (v / 32) % 8);
  endtask

  task automatic patch_cst(input int p, input int v);
    logic [7:0] lv;
    lv = v[7:0];
    prog[p]     = {4'd0, lv[4:0]};
    prog[p + 1] = {4'd14, 2'b00, lv[7:5]};
  endtask

  task automatic jump(input int target);
    cst(target);
    asm_i(1, 7);
    asm_i(13, 7);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 9'h1E0;
  endtask

  // Encrypt one character: R0 = char ^ lfsr, stored at R5. Then the LFSR in R2 steps and R5 increments.
  task automatic emit();
    asm_i(5, 2); asm_i(11, 5);
    asm_i(2, 2); asm_i(9, 3); asm_i(1, 6);
    asm_i(2, 2); asm_i(8, 1); asm_i(7, 6); asm_i(1, 2);
    cst(1); asm_i(1, 6); asm_i(2, 5); asm_i(3, 6); asm_i(1, 5);
  endtask

  task automatic build_enc(input int base);
    int pa, pb, pc_, a_top, b_top, c_top;
    clear_prog();
    apc = base;
    cst(64); asm_i(1, 5);
    cst(42); asm_i(1, 6); asm_i(10, 6); asm_i(1, 3);
    cst(43); asm_i(1, 6); asm_i(10, 6); asm_i(1, 2);
    cst(41); asm_i(1, 6); asm_i(10, 6); asm_i(1, 4);
    asm_i(0, 0); asm_i(1, 1);
    a_top = apc; pa = apc;
    cst(0); asm_i(1, 7); asm_i(2, 4); asm_i(12, 7);
    cst(32); emit();
    cst(1); asm_i(1, 6); asm_i(2, 4); asm_i(4, 6); asm_i(1, 4);
    jump(a_top);
    b_top = apc; patch_cst(pa, b_top); pb = apc;
    cst(0); asm_i(1, 7); cst(41); asm_i(1, 6); asm_i(2, 1); asm_i(4, 6); asm_i(12, 7);
    asm_i(10, 1); emit();
    cst(1); asm_i(1, 6); asm_i(2, 1); asm_i(3, 6); asm_i(1, 1);
    jump(b_top);
    c_top = apc; patch_cst(pb, c_top); pc_ = apc;
    cst(0); asm_i(1, 7); cst(128); asm_i(1, 6); asm_i(2, 5); asm_i(4, 6); asm_i(12, 7);
    cst(32); emit();
    jump(c_top);
    patch_cst(pc_, apc);
    asm_i(15, 0);
  endtask

  // ---------------- run control ----------------
  task automatic load_rom();
    for (int i = 0; i < 256; i++) dut.InstrROM_module.instr_memory[i] = prog[i];
  endtask

  task automatic hold_start(input int sa);
    start = 1'b1;
    start_addr = sa[7:0];
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_to_done(input string name, input int budget);
    int cyc;
    cyc = 0;
    start = 1'b0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: done not seen within %0d cycles, expected 1", name, budget);
      q.delete();
    end else begin
      @(negedge CLK);
      @(negedge CLK);
      check({name, "_drain"}, q.size(), 0);
      q.delete();
    end
  endtask

  task automatic enc_test(input int base, input int pre, input int seed, input int tap,
                          input logic [7:0] m [41], input bit restart);
    int s, ch;
    build_enc(base);
    load_rom();
    hold_start(base);
    for (int i = 0; i < 41; i++) dut.DataRAM_module.my_memory[i] = m[i];
    dut.DataRAM_module.my_memory[41] = pre[7:0];
    dut.DataRAM_module.my_memory[42] = tap[7:0];
    dut.DataRAM_module.my_memory[43] = seed[7:0];
    s = seed;
    for (int i = 0; i < 64; i++) begin
      ch = (i < pre || i >= pre + 41) ? 32 : int'(m[i - pre]);
      q.push_back('{kind: 1, idx: 64 + i, val: 8'((ch ^ s) % 256)});
      s = lfsr_next(s, tap);
    end
    q.push_back('{kind: 1, idx: 42, val: tap[7:0]});
    q.push_back('{kind: 2, idx: 0, val: 8'((apc + 255) % 256)});
    if (restart) begin
      start = 1'b0;
      repeat (300) @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      check("restart_done", int'(done), 0);
      check("restart_pc", int'(dut.r_pc), base);
      @(negedge CLK);
    end
    run_to_done("enc", 8000);
  endtask

  logic [7:0] msg [41];
  string      txt;
  int         a, b, sh, r, held_pc;

  initial begin
    // Test 1: start_addr 5. The first instruction executed must be ROM[5].
    clear_prog();
    apc = 0; asm_i(0, 1); asm_i(1, 2); asm_i(15, 0);
    apc = 5; asm_i(0, 7); asm_i(1, 2); asm_i(15, 0);
    load_rom();
    dut.regFile_module.registers[2] = 8'h00;
    hold_start(5);
    check("reset_done", int'(done), 0);
    check("reset_pc", int'(dut.r_pc), 5);
    q.push_back('{kind: 0, idx: 2, val: 8'd7});
    q.push_back('{kind: 2, idx: 0, val: 8'd7});
    run_to_done("start5", 100);

    // Test 2: directed subtraction, including a wrap below zero.
    clear_prog(); apc = 0;
    asm_i(0, 3); asm_i(1, 1); asm_i(0, 5); asm_i(4, 1); asm_i(1, 2);
    asm_i(4, 1); asm_i(4, 1); asm_i(1, 3); asm_i(15, 0);
    load_rom();
    hold_start(0);
    q.push_back('{kind: 0, idx: 2, val: 8'((5 - 3) % 256)});
    q.push_back('{kind: 0, idx: 3, val: 8'(ref_alu(4, ref_alu(4, 2, 3, 0), 3, 0))});
    run_to_done("alu_sub", 100);

    // Test 3: random ALU operands. Each result is stored to RAM. The first PAR uses 5A/D4.
    for (int round = 0; round < 3; round++) begin
      clear_prog(); apc = 0;
      hold_start(0);
      for (int op = 3; op <= 9; op++) begin
        a  = $urandom_range(0, 255);
        b  = $urandom_range(0, 255);
        sh = $urandom_range(0, 7);
        if (round == 0 && op == 9) begin a = 8'h5A; b = 8'hD4; end
        cst(b); asm_i(1, 1); cst(a);
        asm_i(op, (op == 8) ? sh : 1);
        asm_i(1, 3); cst(128 + op); asm_i(1, 4); asm_i(2, 3); asm_i(11, 4);
        q.push_back('{kind: 1, idx: 128 + op, val: 8'(ref_alu(op, a, b, sh))});
      end
      asm_i(15, 0);
      load_rom();
      run_to_done("alu_rand", 400);
    end

    // Test 4: store then load back, plus a load from a preloaded random location.
    r = $urandom_range(0, 255);
    clear_prog(); apc = 0;
    cst(64); asm_i(1, 1); cst(8'hA5); asm_i(11, 1); asm_i(0, 0); asm_i(10, 1); asm_i(1, 2);
    cst(200); asm_i(1, 4); asm_i(10, 4); asm_i(1, 5); asm_i(15, 0);
    load_rom();
    hold_start(0);
    dut.DataRAM_module.my_memory[200] = r[7:0];
    q.push_back('{kind: 1, idx: 64, val: 8'hA5});
    q.push_back('{kind: 0, idx: 2, val: 8'hA5});
    q.push_back('{kind: 0, idx: 5, val: r[7:0]});
    run_to_done("mem", 100);

    // Test 5: BZ taken skips a write. BNZ not taken falls through. Then HALT holds.
    clear_prog(); apc = 0;
    cst(7); asm_i(1, 1); asm_i(0, 0); asm_i(12, 1); asm_i(0, 1); asm_i(1, 2);
    asm_i(0, 0); asm_i(13, 1); asm_i(0, 3); asm_i(1, 3); asm_i(15, 0);
    load_rom();
    hold_start(0);
    dut.regFile_module.registers[2] = 8'hEE;
    dut.regFile_module.registers[3] = 8'h00;
    q.push_back('{kind: 0, idx: 2, val: 8'hEE});
    q.push_back('{kind: 0, idx: 3, val: 8'h03});
    q.push_back('{kind: 2, idx: 0, val: 8'd11});
    run_to_done("branch", 100);
    held_pc = 11;
    repeat (5) @(negedge CLK);
    check("halt_done_held", int'(done), 1);
    check("halt_pc_held", int'(dut.r_pc), held_pc);

    // Test 6: the message program with pre-length 9 and tap D4, restarted part-way through.
    txt = "Mr. Watson, come here. I want to see you.";
    for (int i = 0; i < 41; i++) msg[i] = txt[i];
    enc_test(0, 9, $urandom_range(1, 255), 8'hD4, msg, 1'b1);

    // Test 7: random message, pre-length and seed, with the program loaded at base 16.
    for (int i = 0; i < 41; i++) msg[i] = 8'($urandom_range(32, 126));
    enc_test(16, $urandom_range(0, 23), $urandom_range(1, 255), 8'hD4, msg, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
